// File: rtl/dp_psum_drain.sv
// dp_psum_drain: drains the DP core partial-sum buffer in linear address
// order and streams each NUM_POLY-wide word on a valid/ready interface.
// Reads are credit-limited against a small skid FIFO, so the buffer read
// latency is hidden and backpressure never drops or repeats a word.
module dp_psum_drain #(
    parameter int COE_WIDTH         = 35,
    parameter int NUM_POLY          = 3,
    parameter int ADDR_WIDTH        = 9,
    parameter int LOG_NUM_BANK      = 3,
    parameter int COMMON_BRAM_DELAY = 1,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_rden,
    output logic [ADDR_WIDTH+LOG_NUM_BANK-1:0]   o_rdaddr,
    input  logic [COE_WIDTH*NUM_POLY-1:0]        i_rddata,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [COE_WIDTH*NUM_POLY-1:0]        o_data,
    output logic                                 o_last,
    output logic [ADDR_WIDTH+LOG_NUM_BANK-1:0]   o_index
);

    localparam int AW = ADDR_WIDTH + LOG_NUM_BANK;
    localparam int DW = COE_WIDTH * NUM_POLY;
    localparam int D  = COMMON_BRAM_DELAY;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } entry_t;

    // FSM / read-issue registers
    state_t        state_q;
    logic [AW:0]   cnt_q;      // reads granted so far; MSB set means all N granted
    logic          rden_q;
    logic [AW-1:0] rdaddr_q;
    logic          busy_q;
    logic          done_q;

    // in-flight tracking and skid FIFO
    logic [D-1:0]         pipe_vld_q, pipe_vld_d;
    logic [D-1:0][AW-1:0] pipe_addr_q, pipe_addr_d;
    logic [CW-1:0]        infl_q, infl_d;
    logic [CW-1:0]        occ_q, occ_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               mem_d [FIFO_DEPTH];
    entry_t               head;

    logic          push, pop;
    logic [AW-1:0] push_addr;
    logic          credit_ok, start_ok, issue, flush_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake, credit and FSM qualifiers. Credits use registered counts
    // only, so a pop frees its slot for reads granted from the next cycle.
    always_comb begin
        push      = pipe_vld_q[D-1];
        push_addr = pipe_addr_q[D-1];
        pop       = (occ_q != '0) && i_ready;
        credit_ok = ((CW+1)'(occ_q) + (CW+1)'(infl_q)) < (CW+1)'(FIFO_DEPTH);
        start_ok  = (state_q == IDLE) && i_start;
        issue     = (state_q == RUN) && !cnt_q[AW] && credit_ok;
        // drained once nothing is in flight and the FIFO empties this cycle
        flush_ok  = (infl_q == '0) &&
                    ((occ_q == '0) || ((occ_q == CW'(1)) && pop));
    end

    // Control FSM with registered read port, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rden_q   <= 1'b0;
            rdaddr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rden_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // FIFO is empty in IDLE, so read 0 is granted with the start
                    if (i_start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        rden_q   <= 1'b1;
                        rdaddr_q <= '0;
                        cnt_q    <= (AW+1)'(1);
                    end
                end
                RUN: begin
                    if (issue) begin
                        rden_q   <= 1'b1;
                        rdaddr_q <= cnt_q[AW-1:0];
                        cnt_q    <= cnt_q + (AW+1)'(1);
                    end
                    if (rden_q && (rdaddr_q == LAST_ADDR)) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (flush_ok) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shift register tracking (valid, addr) of reads until their data returns.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_vld_d[0]  = rden_q;
        pipe_addr_d[0] = rdaddr_q;
        for (int i = 1; i < D; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
    end

    // Next-state for counts, pointers and FIFO storage.
    always_comb begin
        infl_d   = infl_q + CW'(start_ok | issue) - CW'(push);
        occ_d    = occ_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q].data = i_rddata;
            mem_d[wr_ptr_q].idx  = push_addr;
            mem_d[wr_ptr_q].last = (push_addr == LAST_ADDR);
        end
    end

    // Datapath registers; reset also discards reads still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_addr_q <= '0;
            infl_q      <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            infl_q      <= infl_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign o_valid  = (occ_q != '0);
    assign o_data   = head.data;
    assign o_index  = head.idx;
    assign o_last   = head.last;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_rden   = rden_q;
    assign o_rdaddr = rdaddr_q;

endmodule

// File: doc/dp_psum_drain.md
Name: dp_psum_drain

Overview:
Downstream drain stage for the DP core's partial-sum buffer. After the final multiply-add pass completes, it reads every entry of the psum buffer in linear address order and streams each NUM_POLY-wide coefficient word out on a valid/ready interface. It hides the buffer read latency with an internal credit-controlled FIFO, so backpressure never loses or duplicates data. It sits between the psum buffer read port and the DP output path.

Parameters:
COE_WIDTH, 35, width of one coefficient
NUM_POLY, 3, coefficients per buffer word (one per poly)
ADDR_WIDTH, 9, per-bank address width
LOG_NUM_BANK, 3, bank-select width; buffer depth is 1<<(ADDR_WIDTH+LOG_NUM_BANK)
COMMON_BRAM_DELAY, 1, psum buffer read latency in cycles (>=1)
FIFO_DEPTH, 4, skid FIFO entries; must be >= COMMON_BRAM_DELAY+1; full throughput requires >= COMMON_BRAM_DELAY+3

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; ignored unless idle
o_busy  out  1  high from the cycle after an accepted start until o_done
o_done  out  1  one-cycle pulse after the last output handshake
o_rden  out  1  psum buffer read enable
o_rdaddr  out  ADDR_WIDTH+LOG_NUM_BANK  psum buffer read address; bank in MSBs
i_rddata  in  COE_WIDTH*NUM_POLY  psum buffer read data, valid COMMON_BRAM_DELAY cycles after o_rden
o_valid  out  1  output word valid
i_ready  in  1  downstream ready
o_data  out  COE_WIDTH*NUM_POLY  output word; poly p at [COE_WIDTH*p +: COE_WIDTH]
o_last  out  1  high with the final word (address N-1)
o_index  out  ADDR_WIDTH+LOG_NUM_BANK  buffer address of the current o_data word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0, address counter 0.
- N = 1<<(ADDR_WIDTH+LOG_NUM_BANK); 4096 with defaults.
- FSM states:
  - IDLE: i_start moves to RUN. The address counter is cleared to 0.
  - RUN: issues reads. Moves to FLUSH in the cycle after the read at address N-1 is issued.
  - FLUSH: waits until in-flight = 0, FIFO empty, and the last word has handshaken. Then moves to DONE.
  - DONE: one cycle. o_done = 1, then IDLE.
- o_busy = 1 in RUN, FLUSH and DONE.
- Read issue:
  - In RUN, o_rden = 1 when (FIFO occupancy + in-flight reads) < FIFO_DEPTH, using registered counts. A pop in the same cycle frees a credit only from the next cycle.
  - o_rdaddr = counter. The counter increments per issued read and never wraps within a run.
  - o_rden and o_rdaddr are registered. First read: o_rden = 1, addr 0, in cycle S+1, where S is the i_start cycle.
- Capture:
  - A COMMON_BRAM_DELAY-deep shift register of (valid, addr) tracks in-flight reads.
  - i_rddata is pushed into the FIFO, tagged with its address and last flag, exactly COMMON_BRAM_DELAY cycles after its o_rden.
  - Push never occurs when full; the credit rule guarantees this. Overflow is a verification assertion.
- Output:
  - o_valid/o_data/o_index/o_last are driven from the FIFO head register.
  - A handshake is o_valid & i_ready. It pops the head.
  - While o_valid & !i_ready, o_data, o_index and o_last hold stable.
  - o_valid never drops without a handshake.
- Latency with i_ready = 1: first o_valid at cycle S+2+COMMON_BRAM_DELAY. Throughput is 1 word per cycle when FIFO_DEPTH >= COMMON_BRAM_DELAY+3.
- Simultaneous push and pop on the same cycle: both are performed; occupancy is unchanged.
- i_start while busy: ignored, with no effect on state or counters.
- Reset mid-run: immediate clear to reset values. No o_done pulse. In-flight read data returning after reset is discarded.
- Data is passed unmodified; no arithmetic is performed on coefficients.

Test Plan:
- Back-to-back stream (defaults, i_ready = 1, buffer word at addr a = {a+2, a+1, a}):
  - first o_valid at S+3 with o_index 0;
  - 4096 consecutive handshakes, o_index 0..4095, data matches;
  - o_last only at 4095;
  - o_done at S+4099; o_busy low afterwards.
- Backpressure: i_ready low for 20 cycles starting at the 10th word ->
  - o_data/o_index hold at 9 during the stall;
  - at most FIFO_DEPTH - (occupancy) reads are issued during the stall;
  - no overflow; the sequence resumes with no gaps or duplicates.
- Random i_ready at 30% duty with COMMON_BRAM_DELAY = 3, FIFO_DEPTH = 4 ->
  - all 4096 words delivered in order;
  - FIFO never overflows (assertion);
  - o_done after word 4095.
- i_start pulsed again in RUN at word 100 -> ignored; exactly 4096 words and one o_done.
- rst_n asserted at word 2000 with reads in flight ->
  - all outputs 0 asynchronously; no o_done;
  - a new i_start after release restarts from o_index 0.
- Small config (ADDR_WIDTH = 2, LOG_NUM_BANK = 1, N = 8), i_ready = 0 until cycle S+20 ->
  - o_rden stops after FIFO_DEPTH credits are used;
  - 8 words delivered afterwards with o_last on index 7.
